srec_stream_loader: RTL and testbench
=====================================

Name: srec_stream_loader

Overview:
Synthesizable replacement for the simulation-only SREC file loader. It accepts an ASCII SREC character stream, such as UART receive output, over a valid/ready handshake. It parses S0–S9 records and verifies each checksum. Record data is buffered and written to the memory block as byte writes only after the checksum passes. It holds the fetch unit in stall until a termination record (S7/S8/S9) arrives, then presents that record's address as the entry PC.

Parameters:
MAX_DATA, 32, maximum data bytes per record that the line buffer can hold.
BUF_AW, 5, line buffer index width; must satisfy 2**BUF_AW >= MAX_DATA.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
char_in  in  8  ASCII character.
char_valid_in  in  1  char_in is valid this cycle.
char_ready_out  out  1  loader accepts char_in this cycle; a transfer occurs when valid && ready.
mem_address_out  out  32  byte address to memory.
mem_data_out  out  32  write data; [7:0] carries the byte, [31:8] are always 0.
mem_write_out  out  1  single-cycle write strobe.
mem_access_size_out  out  2  always 2'b00 (byte).
stall_out  out  1  connects to fetch stall_in; high until load completes.
entry_pc_out  out  32  address from the termination record.
load_done_out  out  1  sticky; set on a valid S7/S8/S9 record.
error_out  out  1  sticky; set on any parse, checksum or length error.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE.
  - mem_* = 0, entry_pc_out = 0, load_done_out = 0, error_out = 0.
  - stall_out = 1.
  - char_ready_out = 1 once out of reset.
- Handshake: char_ready_out = 1 in IDLE, TYPE, COUNT, ADDR, DATA, CSUM and EOL. It is 0 in DRAIN, DONE and ERR. Each accepted character is processed in the cycle it is accepted.
- Hex decode: '0'–'9', 'A'–'F' and 'a'–'f' are valid. Any other character where a hex digit is expected goes to ERR.
- IDLE: 'S' goes to TYPE. CR (0x0D) and LF (0x0A) are ignored. Anything else goes to ERR.
- TYPE: the digit sets the address length.
  - 0/1/5/9: 2 bytes.
  - 2/8: 3 bytes.
  - 3/7: 4 bytes.
  - 6: 3 bytes.
  - 4 or any non-digit: ERR.
- COUNT: two nibbles, high first.
  - Error if count < addr_len + 1.
  - Error if data_len = count − addr_len − 1 > MAX_DATA.
  - Both checks happen on the cycle the low nibble is accepted.
- ADDR: 2×addr_len nibbles, most significant first, zero-extended to 32 bits.
- DATA: data_len bytes, two nibbles each. Each assembled byte goes into the line buffer at index i. When data_len = 0, DATA is skipped.
- CSUM: two nibbles.
  - Running sum is the low 8 bits of count + every address byte + every data byte + the checksum byte.
  - Pass: sum == 8'hFF.
  - Fail: go to ERR; no memory write is issued for that record.
- On pass:
  - S1/S2/S3 with data_len > 0: go to DRAIN.
  - S7/S8/S9: latch entry_pc_out = address, set load_done_out, go to EOL.
  - S0/S5/S6, or data_len = 0: go to EOL with no writes.
- DRAIN: one write per cycle for i = 0..data_len−1.
  - mem_write_out = 1, mem_address_out = addr + i (modulo 2^32, wraps), mem_data_out = {24'h0, buf[i]}.
  - The first strobe is the cycle after the checksum's low nibble is accepted. Strobes are contiguous.
  - Then go to EOL.
- EOL: CR is ignored. LF goes to IDLE, or to DONE if load_done_out is set. Any other character goes to ERR. An LF received before CSUM completes goes to ERR.
- DONE: stall_out = 0; all later input is refused.
- ERR: stall_out stays 1, error_out = 1, state held until reset.
- Outside DRAIN: mem_write_out = 0; address and data hold their last values.
- Reset mid-DRAIN: the write stops immediately and all outputs return to their reset values. Bytes already written stay in memory.

Decomposition:
- Package srec_pkg holds:
  - the state enumeration;
  - ASCII constants 'S', CR, LF;
  - ACCESS_BYTE = 2'b00;
  - a function mapping record type to address length;
  - an ASCII-to-nibble function that returns a valid flag.
- Sub-module srec_line_buffer: MAX_DATA × 8 register array with a write port indexed during DATA and a read port indexed during DRAIN. It has no reset on the storage.

Test Plan:
- "S107000001020304EE\n" → four strobes: address 0x0–0x3, data 0x01–0x04, all on consecutive cycles, access size 00. error_out = 0.
- "S30980020000AABBCCDD66\n" → writes 0x80020000 = AA, …0001 = BB, …0002 = CC, …0003 = DD. Then "S7058002000078\n" → entry_pc_out = 0x80020000, load_done_out = 1, stall_out = 0, char_ready_out = 0.
- "S107000001020304EF\n" (bad checksum) → zero strobes, error_out = 1, stall_out = 1, char_ready_out = 0.
- With MAX_DATA = 4, "S108…" → error_out = 1 on the cycle the count's low nibble is accepted; no writes.
- Blank lines, CRLF endings, lowercase hex, and char_valid_in toggling randomly → results identical to the first scenario; "S4…" or 'G' in the data field → ERR.
- rst_n asserted mid-DRAIN on the second byte → strobe drops asynchronously and all outputs return to reset values. A following valid record loads normally.

Source files
------------

// File: rtl/srec_pkg.sv
// Shared types, ASCII constants and decode helpers
// for the SREC stream loader.
package srec_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TYPE,
    S_COUNT,
    S_ADDR,
    S_DATA,
    S_CSUM,
    S_DRAIN,
    S_EOL,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam logic [1:0] ACCESS_BYTE = 2'b00;

  // Address bytes for a record type digit; 0 marks an illegal type.
  function automatic logic [2:0] addr_len(input logic [7:0] c);
    case (c)
      8'h30, 8'h31, 8'h35, 8'h39: return 3'd2;
      8'h32, 8'h36, 8'h38:        return 3'd3;
      8'h33, 8'h37:               return 3'd4;
      default:                    return 3'd0;
    endcase
  endfunction

  // Returns {valid, nibble}.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    if ((c >= 8'h41 && c <= 8'h46) ||
        (c >= 8'h61 && c <= 8'h66))
      return {1'b1, c[3:0] + 4'd9};
    return 5'b0;
  endfunction

endpackage

// File: rtl/srec_stream_loader_if.sv
// Character stream and byte-write memory bus
// between a char source and the SREC loader.
interface srec_stream_loader_if;
  logic [7:0]  char_in;
  logic        char_valid_in;
  logic        char_ready_out;
  logic [31:0] mem_address_out;
  logic [31:0] mem_data_out;
  logic        mem_write_out;
  logic [1:0]  mem_access_size_out;

  modport master (
    output char_in, char_valid_in,
    input  char_ready_out,
    input  mem_address_out, mem_data_out,
    input  mem_write_out, mem_access_size_out
  );

  modport slave (
    input  char_in, char_valid_in,
    output char_ready_out,
    output mem_address_out, mem_data_out,
    output mem_write_out, mem_access_size_out
  );
endinterface

// File: rtl/srec_stream_loader_line_buffer.sv
// Record data line buffer: written while parsing,
// read back while draining to memory.
module srec_line_buffer #(
  parameter int MAX_DATA = 32,
  parameter int BUF_AW   = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BUF_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [BUF_AW-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [MAX_DATA];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/srec_stream_loader.sv
// Parses an ASCII SREC stream, checks each record and
// writes verified data bytes; releases fetch stall on S7/8/9.
module srec_stream_loader
  import srec_pkg::*;
#(
  parameter int MAX_DATA = 32,
  parameter int BUF_AW   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  srec_stream_loader_if.slave bus,
  output logic        stall_out,
  output logic [31:0] entry_pc_out,
  output logic        load_done_out,
  output logic        error_out
);
  localparam logic [8:0] MAXD = 9'(MAX_DATA);

  state_t      state, state_n;
  logic [3:0]  rtype, hi_nib, nib_cnt, nib;
  logic [2:0]  alen;
  logic [7:0]  dlen, sum, idx, byte_v, rd_byte;
  logic [8:0]  need, rem;
  logic [31:0] addr;
  logic        phase, acc, hv, hex_acc;
  logic        is_data, is_term, sum_ok, buf_we;

  assign {hv, nib} = hex_nib(bus.char_in);
  assign byte_v    = {hi_nib, nib};
  assign need      = 9'(alen) + 9'd1;
  assign rem       = {1'b0, byte_v} - need;
  assign sum_ok    = (sum + byte_v) == 8'hFF;
  assign is_data   = rtype inside {4'd1, 4'd2, 4'd3};
  assign is_term   = rtype inside {4'd7, 4'd8, 4'd9};

  assign bus.char_ready_out =
    !(state inside {S_DRAIN, S_DONE, S_ERR});
  assign acc     = bus.char_valid_in & bus.char_ready_out;
  assign hex_acc = acc & hv;

  assign bus.mem_write_out       = state == S_DRAIN;
  assign bus.mem_access_size_out = ACCESS_BYTE;
  assign stall_out = state != S_DONE;
  assign error_out = state == S_ERR;
  assign buf_we    = state == S_DATA && hex_acc && phase;

  srec_line_buffer #(
    .MAX_DATA(MAX_DATA),
    .BUF_AW  (BUF_AW)
  ) u_line_buf (
    .clk  (clk),
    .we   (buf_we),
    .waddr(idx[BUF_AW-1:0]),
    .wdata(byte_v),
    .raddr(state == S_DRAIN ? idx[BUF_AW-1:0] : '0),
    .rdata(rd_byte)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (acc) begin
        if (bus.char_in == CH_S)
          state_n = S_TYPE;
        else if (!(bus.char_in inside {CH_CR, CH_LF}))
          state_n = S_ERR;
      end
      S_TYPE: if (acc)
        state_n = addr_len(bus.char_in) != 3'd0
                  ? S_COUNT : S_ERR;
      S_COUNT: if (acc) begin
        if (!hv) state_n = S_ERR;
        else if (phase)
          state_n = ({1'b0, byte_v} < need || rem > MAXD)
                    ? S_ERR : S_ADDR;
      end
      S_ADDR: if (acc) begin
        if (!hv) state_n = S_ERR;
        else if (nib_cnt == {alen, 1'b0} - 4'd1)
          state_n = dlen == 8'd0 ? S_CSUM : S_DATA;
      end
      S_DATA: if (acc) begin
        if (!hv) state_n = S_ERR;
        else if (phase && idx == dlen - 8'd1)
          state_n = S_CSUM;
      end
      S_CSUM: if (acc) begin
        if (!hv) state_n = S_ERR;
        else if (phase) begin
          if (!sum_ok) state_n = S_ERR;
          else if (is_data && dlen != 8'd0) state_n = S_DRAIN;
          else state_n = S_EOL;
        end
      end
      S_DRAIN: if (idx == dlen) state_n = S_EOL;
      S_EOL: if (acc) begin
        if (bus.char_in == CH_LF)
          state_n = load_done_out ? S_DONE : S_IDLE;
        else if (bus.char_in != CH_CR)
          state_n = S_ERR;
      end
      S_DONE:  state_n = S_DONE;
      S_ERR:   state_n = S_ERR;
      default: state_n = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      rtype               <= '0;
      alen                <= '0;
      hi_nib              <= '0;
      phase               <= 1'b0;
      nib_cnt             <= '0;
      dlen                <= '0;
      sum                 <= '0;
      idx                 <= '0;
      addr                <= '0;
      entry_pc_out        <= '0;
      load_done_out       <= 1'b0;
      bus.mem_address_out <= '0;
      bus.mem_data_out    <= '0;
    end else begin
      state <= state_n;
      if (hex_acc &&
          state inside {S_COUNT, S_ADDR, S_DATA, S_CSUM}) begin
        phase <= ~phase;
        if (!phase) hi_nib <= nib;
      end
      if (state == S_TYPE && acc) begin
        rtype <= bus.char_in[3:0];
        alen  <= addr_len(bus.char_in);
      end
      if (state == S_COUNT && hex_acc && phase) begin
        sum     <= byte_v;
        dlen    <= rem[7:0];
        addr    <= '0;
        nib_cnt <= '0;
        idx     <= '0;
      end
      if (state == S_ADDR && hex_acc) begin
        addr    <= {addr[27:0], nib};
        nib_cnt <= nib_cnt + 4'd1;
        if (phase) sum <= sum + byte_v;
      end
      if (state == S_DATA && hex_acc && phase) begin
        sum <= sum + byte_v;
        idx <= idx + 8'd1;
      end
      // Preload the first write so strobes start right after the checksum.
      if (state == S_CSUM && hex_acc && phase && sum_ok) begin
        if (state_n == S_DRAIN) begin
          idx                 <= 8'd1;
          bus.mem_address_out <= addr;
          bus.mem_data_out    <= {24'h0, rd_byte};
        end
        if (is_term) begin
          entry_pc_out  <= addr;
          load_done_out <= 1'b1;
        end
      end
      if (state == S_DRAIN && idx != dlen) begin
        idx                 <= idx + 8'd1;
        bus.mem_address_out <= bus.mem_address_out + 32'd1;
        bus.mem_data_out    <= {24'h0, rd_byte};
      end
    end
  end
endmodule

// File: tb/tb_srec_stream_loader.sv
// Scoreboard bench for srec_stream_loader: directed
// records in, expected byte writes checked by a monitor.
module tb_srec_stream_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_out, load_done_out, error_out;
  logic [31:0] entry_pc_out;

  srec_stream_loader_if bus ();

  srec_stream_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .stall_out    (stall_out),
    .entry_pc_out (entry_pc_out),
    .load_done_out(load_done_out),
    .error_out    (error_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
    logic        first;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  logic prev_we = 1'b0;
  bit   jitter = 1'b0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic void exp_wr(logic [31:0] a, logic [7:0] d,
                                 logic f);
    exp_q.push_back({a, d, f});
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (rst_n && bus.mem_write_out) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got addr %h data %h, required none",
                 bus.mem_address_out, bus.mem_data_out);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", bus.mem_address_out, e.a);
        check("wr_data", bus.mem_data_out, {24'h0, e.d});
        check("wr_size", 32'(bus.mem_access_size_out), 32'd0);
        if (!e.first) check("wr_contig", 32'(prev_we), 32'd1);
      end
    end
    prev_we = rst_n && bus.mem_write_out;
  end

  task automatic send_ch(input byte c, output bit ok);
    int n = 0;
    if (jitter)
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    bus.char_in = c;
    bus.char_valid_in = 1'b1;
    ok = 1'b0;
    while (!ok && n < 50) begin
      ok = bus.char_ready_out;
      @(posedge clk); #1;
      n++;
    end
    bus.char_valid_in = 1'b0;
  endtask

  task automatic send_str(input string s);
    bit ok;
    for (int i = 0; i < s.len(); i++) begin
      send_ch(s[i], ok);
      if (!ok) begin
        n_chk++;
        $display("FAIL send_timeout: char %h not accepted, required accept",
                 s[i]);
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.char_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push_rec1();
    for (int i = 0; i < 4; i++)
      exp_wr(32'(i), 8'(i + 1), i == 0);
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.char_in = 8'h0;
    bus.char_valid_in = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall_out), 32'd1);
    check("rst_we", 32'(bus.mem_write_out), 32'd0);
    check("rst_addr", bus.mem_address_out, 32'd0);
    check("rst_data", bus.mem_data_out, 32'd0);
    check("rst_pc", entry_pc_out, 32'd0);
    check("rst_done", 32'(load_done_out), 32'd0);
    check("rst_err", 32'(error_out), 32'd0);
    rst_n = 1'b1;
    #1 check("rst_ready", 32'(bus.char_ready_out), 32'd1);

    push_rec1();
    send_str("S107000001020304EE\n");
    settle();
    check("s1_err", 32'(error_out), 32'd0);
    check("s1_done", 32'(load_done_out), 32'd0);
    check("s1_stall", 32'(stall_out), 32'd1);

    send_str("S00600004844521B\n");
    settle();
    check("s0_err", 32'(error_out), 32'd0);
    check("s0_ready", 32'(bus.char_ready_out), 32'd1);

    exp_wr(32'h80020000, 8'hAA, 1'b1);
    exp_wr(32'h80020001, 8'hBB, 1'b0);
    exp_wr(32'h80020002, 8'hCC, 1'b0);
    exp_wr(32'h80020003, 8'hDD, 1'b0);
    send_str("S30980020000AABBCCDD66\n");
    send_str("S7058002000078\n");
    settle();
    check("s7_pc", entry_pc_out, 32'h80020000);
    check("s7_done", 32'(load_done_out), 32'd1);
    check("s7_stall", 32'(stall_out), 32'd0);
    check("s7_ready", 32'(bus.char_ready_out), 32'd0);
    check("s7_err", 32'(error_out), 32'd0);

    do_reset();
    send_str("S107000001020304EF");
    settle();
    check("bad_ck_err", 32'(error_out), 32'd1);
    check("bad_ck_stall", 32'(stall_out), 32'd1);
    check("bad_ck_ready", 32'(bus.char_ready_out), 32'd0);

    do_reset();
    send_str("S124");
    check("cnt_big_err", 32'(error_out), 32'd1);
    do_reset();
    send_str("S102");
    check("cnt_small_err", 32'(error_out), 32'd1);
    do_reset();
    send_str("S1030000FC\n");
    settle();
    check("cnt_min_err", 32'(error_out), 32'd0);

    do_reset();
    jitter = 1'b1;
    push_rec1();
    send_str("\n\015\nS107000001020304ee\015\n");
    jitter = 1'b0;
    settle();
    check("jit_err", 32'(error_out), 32'd0);

    do_reset();
    send_str("S4");
    check("s4_err", 32'(error_out), 32'd1);
    do_reset();
    send_str("S1070000G");
    check("g_err", 32'(error_out), 32'd1);
    do_reset();
    send_str("S107\n");
    check("early_lf_err", 32'(error_out), 32'd1);

    do_reset();
    exp_wr(32'h0, 8'h01, 1'b1);
    send_str("S107000001020304EE");
    check("drain_we1", 32'(bus.mem_write_out), 32'd1);
    @(posedge clk); #1;
    check("drain_addr2", bus.mem_address_out, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(bus.mem_write_out), 32'd0);
    check("mid_rst_addr", bus.mem_address_out, 32'd0);
    check("mid_rst_data", bus.mem_data_out, 32'd0);
    check("mid_rst_stall", 32'(stall_out), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("mid_rst_ready", 32'(bus.char_ready_out), 32'd1);
    push_rec1();
    send_str("S107000001020304EE\n");
    settle();
    check("post_rst_err", 32'(error_out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
